sfr_bank: RTL and testbench
===========================

Name: sfr_bank

Overview:
- Parametrised special-function-register bank for the DW8051 SFR bus. Successor to the flat 256-entry SFR memory model.
- Decodes an address window, stores DEPTH registers of DATA_W bits and applies per-bit access policies: read-write, read-only, write-1-to-clear.
- Merges hardware status-set inputs from attached peripherals (e.g. the I2C master).
- Gives the core a registered read path and gives peripherals per-register write/read strobes.

Parameters:
- DATA_W, 8: register and bus data width.
- ADDR_W, 8: SFR address width.
- BASE, 8'h80: address of register 0; window is BASE..BASE+DEPTH-1. BASE+DEPTH <= 2**ADDR_W is required.
- DEPTH, 16: number of registers.
- RESET_VAL, 0: DEPTH*DATA_W flat reset image; register i is bits [i*DATA_W +: DATA_W].
- RO_MASK, 0: DEPTH*DATA_W flat mask; 1 = bit is CPU read-only.
- W1C_MASK, 0: DEPTH*DATA_W flat mask; 1 = CPU write of 1 clears the bit. RO takes precedence over W1C.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: reset, synchronous, active-high.
- addr, input, ADDR_W: SFR address from core.
- data_out, input, DATA_W: write data from core (named from core's view).
- data_in, output, DATA_W: read data to core (named from core's view).
- wr_n, input, 1: write strobe, active-low, sampled each clk.
- rd_n, input, 1: read strobe, active-low, sampled each clk.
- rd_valid, output, 1: one-cycle pulse, data_in updated by an in-window read.
- hw_set, input, DEPTH*DATA_W: peripheral status-set bits, ORed into registers.
- regs_q, output, DEPTH*DATA_W: current contents of all registers, flat.
- wr_strb, output, DEPTH: one-hot pulse, register i was CPU-written in the previous cycle.
- rd_strb, output, DEPTH: one-hot pulse, register i was CPU-read in the previous cycle.

Behaviour:
- Reset (rst=1 at clk edge): regs = RESET_VAL; data_in = 0; rd_valid = 0; wr_strb = 0; rd_strb = 0. rst dominates all other inputs in that cycle; an access in flight is dropped.
- Hit: hit = (addr >= BASE) && (addr < BASE+DEPTH); idx = addr - BASE, ADDR_W-bit unsigned.
- Write, wr_n=0 and hit. Per bit b of reg[idx], next value is:
  - RO bit: old | hw_set.
  - W1C bit: (old & ~data_out) | hw_set.
  - RW bit: data_out | hw_set.
- Write strobe: wr_strb[idx] pulses one cycle after the write; register already holds the new value in that cycle.
- Write miss (wr_n=0, no hit): no register change, no strobe.
- No write on a register: reg next = reg | hw_set slice, every cycle.
- hw_set vs CPU clear/write on the same bit, same cycle: set wins (final bit 1).
- Read, rd_n=0:
  - Hit: data_in <= reg[idx] pre-update value; rd_valid <= 1; rd_strb[idx] <= 1. Latency is 1 cycle.
  - Miss: data_in <= 0; rd_valid <= 0.
  - rd_n=1: data_in holds its previous value; rd_valid <= 0.
- Read and write same cycle, same address: data_in returns the old value; the write lands as normal.
- wr_n and rd_n held low for N cycles: treated as N independent accesses. Strobes pulse every cycle, back-to-back.
- regs_q: registered output, reflects state after the current edge; no combinational path from inputs.
- Width rules: idx truncated to clog2(DEPTH) bits only after the hit check. DEPTH = 1 is legal.

Decomposition:
- Package sfr_pkg holds:
  - access-policy encoding constants (RW/RO/W1C);
  - function sfr_next_bit(policy, old, wdata, we, set);
  - function window_hit(addr, base, depth).
- One natural sub-module: sfr_addr_decode (addr -> hit, idx, one-hot sel). Instantiated once and shared by the read and write paths.
- Top level holds register storage and per-bit policy generate loops.

Test Plan:
- Reset, then read each register with defaults BASE=8'h80, DEPTH=16, RESET_VAL reg3=8'hA5 -> read addr 8'h83: data_in=8'hA5 one cycle after rd_n low, rd_valid=1, rd_strb=16'h0008.
- Write 8'h3C to 8'h81 (reg1 RW) -> regs_q reg1=8'h3C next edge, wr_strb=16'h0002 for exactly one cycle; readback = 8'h3C.
- Policy check: RO_MASK reg2=8'hF0, W1C_MASK reg2=8'h0F, reg2=8'hFF, write 8'h05 -> reg2=8'hFA. Then hw_set reg2=8'h01 with a CPU write of 8'h01 in the same cycle -> bit0 remains 1.
- Out-of-window: write 8'h77 to 8'h7F and 8'h90 -> no register or strobe change. Read 8'h90 -> data_in=0, rd_valid=0.
- Read and write same cycle on 8'h84 (old 8'h11, write 8'h22) -> data_in=8'h11; a following read returns 8'h22.
- Reset mid-stream: assert rst during a back-to-back write burst -> all regs = RESET_VAL, strobes 0. The next write after deassertion is the first to take effect.

Source files
------------

// File: rtl/sfr_pkg.sv
// Shared definitions for the SFR bank: per-bit access policies and the
// address window and next-state helpers used by the decode and storage logic.
package sfr_pkg;

    typedef enum logic [1:0] {
        POL_RW  = 2'd0,
        POL_RO  = 2'd1,
        POL_W1C = 2'd2
    } sfr_policy_e;

    // Peripheral set always wins over a CPU clear or write on the same bit.
    function automatic logic sfr_next_bit(
        input sfr_policy_e policy,
        input logic        old,
        input logic        wdata,
        input logic        we,
        input logic        set
    );
        logic nxt;
        nxt = old;
        if (we) begin
            case (policy)
                POL_RW:  nxt = wdata;
                POL_W1C: nxt = old & ~wdata;
                default: nxt = old;
            endcase
        end
        return nxt | set;
    endfunction

    // Wide arithmetic so that BASE+DEPTH cannot wrap for a full address space.
    function automatic logic window_hit(
        input longint unsigned addr,
        input longint unsigned base,
        input longint unsigned depth
    );
        return (addr >= base) && (addr < base + depth);
    endfunction

endpackage

// File: rtl/sfr_addr_decode.sv
// Address window decode for the SFR bank: hit flag, register index and
// one-hot select, shared by the read and write paths.
module sfr_addr_decode
    import sfr_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned BASE   = 'h80,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic [DEPTH-1:0]  sel
);

    logic [ADDR_W-1:0] offset;

    // The index is only narrowed after the full-width hit test.
    always_comb begin
        hit    = window_hit(64'(addr), 64'(BASE), 64'(DEPTH));
        offset = addr - ADDR_W'(BASE);
        idx    = offset[IDX_W-1:0];
        sel    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sel[i] = hit && (offset == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/sfr_bank.sv
// Parametrised SFR bank on the DW8051 SFR bus: per-bit RW/RO/W1C policy,
// peripheral status-set merge, registered read path and access strobes.
module sfr_bank
    import sfr_pkg::*;
#(
    parameter int unsigned               DATA_W    = 8,
    parameter int unsigned               ADDR_W    = 8,
    parameter int unsigned               BASE      = 'h80,
    parameter int unsigned               DEPTH     = 16,
    parameter logic [DEPTH*DATA_W-1:0]   RESET_VAL = '0,
    parameter logic [DEPTH*DATA_W-1:0]   RO_MASK   = '0,
    parameter logic [DEPTH*DATA_W-1:0]   W1C_MASK  = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         data_out,
    output logic [DATA_W-1:0]         data_in,
    input  logic                      wr_n,
    input  logic                      rd_n,
    output logic                      rd_valid,
    input  logic [DEPTH*DATA_W-1:0]   hw_set,
    output logic [DEPTH*DATA_W-1:0]   regs_q,
    output logic [DEPTH-1:0]          wr_strb,
    output logic [DEPTH-1:0]          rd_strb
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                    hit;
    logic [IDX_W-1:0]        idx;
    logic [DEPTH-1:0]        sel;
    logic [DEPTH-1:0]        we_sel;
    logic [DEPTH*DATA_W-1:0] regs;
    logic [DEPTH*DATA_W-1:0] regs_next;
    logic [DATA_W-1:0]       reg_arr [DEPTH];

    sfr_addr_decode #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_decode (
        .addr   (addr),
        .hit    (hit),
        .idx    (idx),
        .sel    (sel)
    );

    assign we_sel = wr_n ? '0 : sel;
    assign regs_q = regs;

    // Policy is resolved per bit at elaboration; RO masks out W1C.
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        assign reg_arr[r] = regs[r*DATA_W +: DATA_W];
        for (genvar b = 0; b < DATA_W; b++) begin : g_bit
            localparam int unsigned K   = r*DATA_W + b;
            localparam sfr_policy_e POL = RO_MASK[K]  ? POL_RO  :
                                          W1C_MASK[K] ? POL_W1C : POL_RW;
            assign regs_next[K] = sfr_next_bit(POL, regs[K], data_out[b],
                                               we_sel[r], hw_set[K]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs     <= RESET_VAL;
            data_in  <= '0;
            rd_valid <= 1'b0;
            wr_strb  <= '0;
            rd_strb  <= '0;
        end else begin
            regs     <= regs_next;
            wr_strb  <= we_sel;
            rd_strb  <= rd_n ? '0 : sel;
            rd_valid <= 1'b0;
            if (!rd_n) begin
                if (hit) begin
                    data_in  <= reg_arr[idx];
                    rd_valid <= 1'b1;
                end else begin
                    data_in  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sfr_bank.sv
// Self-checking bench for sfr_bank: directed plan steps followed by random
// traffic, all compared against a behavioural register-file model.
module tb_sfr_bank;

    localparam logic [127:0] RST_IMG = 128'h0000_0000_0000_0000_0000_0000_A5FF_0000;
    localparam logic [127:0] RO_IMG  = 128'h0000_0000_0000_0000_0000_0000_00F0_0000;
    localparam logic [127:0] W1C_IMG = 128'h0000_0000_0000_0000_0000_0000_000F_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   addr;
    logic [7:0]   data_out;
    logic [7:0]   data_in;
    logic         wr_n;
    logic         rd_n;
    logic         rd_valid;
    logic [127:0] hw_set;
    logic [127:0] regs_q;
    logic [15:0]  wr_strb;
    logic [15:0]  rd_strb;

    int unsigned total = 0;
    int unsigned fails = 0;

    logic [7:0]  m_reg [16];
    logic [7:0]  m_din;
    logic        m_valid;
    logic [15:0] m_wstrb;
    logic [15:0] m_rstrb;

    always #5 clk = ~clk;

    sfr_bank #(
        .DATA_W    (8),
        .ADDR_W    (8),
        .BASE      ('h80),
        .DEPTH     (16),
        .RESET_VAL (RST_IMG),
        .RO_MASK   (RO_IMG),
        .W1C_MASK  (W1C_IMG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_out (data_out),
        .data_in  (data_in),
        .wr_n     (wr_n),
        .rd_n     (rd_n),
        .rd_valid (rd_valid),
        .hw_set   (hw_set),
        .regs_q   (regs_q),
        .wr_strb  (wr_strb),
        .rd_strb  (rd_strb)
    );

    function automatic logic [127:0] m_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[i*8 +: 8] = m_reg[i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: reads see the pre-edge contents; writes blend by mask arithmetic.
    task automatic model(input logic r, input logic [7:0] a, input logic [7:0] wd,
                         input logic w_n, input logic r_n, input logic [127:0] hs);
        int  idx;
        bit  in_win;
        logic [7:0] ro, w1c, rw, old, st;
        in_win = (a >= 8'h80) && (a <= 8'h8F);
        idx    = int'(a) - 'h80;
        if (r) begin
            for (int i = 0; i < 16; i++) m_reg[i] = RST_IMG[i*8 +: 8];
            m_din = '0; m_valid = 1'b0; m_wstrb = '0; m_rstrb = '0;
            return;
        end
        m_valid = 1'b0;
        m_rstrb = '0;
        m_wstrb = '0;
        if (!r_n) begin
            if (in_win) begin
                m_din = m_reg[idx]; m_valid = 1'b1; m_rstrb = 16'(1) << idx;
            end else begin
                m_din = '0;
            end
        end
        if (!w_n && in_win) m_wstrb = 16'(1) << idx;
        for (int i = 0; i < 16; i++) begin
            old = m_reg[i];
            st  = hs[i*8 +: 8];
            if (!w_n && in_win && i == idx) begin
                ro  = RO_IMG[i*8 +: 8];
                w1c = W1C_IMG[i*8 +: 8] & ~ro;
                rw  = ~(ro | w1c);
                m_reg[i] = (old & ro) | (old & ~wd & w1c) | (wd & rw) | st;
            end else begin
                m_reg[i] = old | st;
            end
        end
    endtask

    task automatic step(input logic r, input logic [7:0] a, input logic [7:0] wd,
                        input logic w_n, input logic r_n, input logic [127:0] hs);
        rst = r; addr = a; data_out = wd; wr_n = w_n; rd_n = r_n; hw_set = hs;
        model(r, a, wd, w_n, r_n, hs);
        @(posedge clk);
        #1;
        chk("regs_q",   regs_q,   m_flat());
        chk("data_in",  {120'd0, data_in}, {120'd0, m_din});
        chk("rd_valid", {127'd0, rd_valid}, {127'd0, m_valid});
        chk("wr_strb",  {112'd0, wr_strb},  {112'd0, m_wstrb});
        chk("rd_strb",  {112'd0, rd_strb},  {112'd0, m_rstrb});
    endtask

    initial begin
        logic [127:0] hs;
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_din = '0; m_valid = 1'b0; m_wstrb = '0; m_rstrb = '0;

        step(1, 8'h00, 8'h00, 1, 1, '0);
        step(1, 8'h00, 8'h00, 1, 1, '0);
        chk("reset_image", regs_q, RST_IMG);

        step(0, 8'h83, 8'h00, 1, 0, '0);
        chk("rd83_data",  {120'd0, data_in}, {120'd0, 8'hA5});
        chk("rd83_valid", {127'd0, rd_valid}, 128'd1);
        chk("rd83_strb",  {112'd0, rd_strb}, {112'd0, 16'h0008});
        for (int i = 0; i < 16; i++) step(0, 8'(8'h80 + i), 8'h00, 1, 0, '0);

        step(0, 8'h81, 8'h3C, 0, 1, '0);
        chk("wr81_reg",  {120'd0, regs_q[15:8]}, {120'd0, 8'h3C});
        chk("wr81_strb", {112'd0, wr_strb}, {112'd0, 16'h0002});
        step(0, 8'h81, 8'h00, 1, 1, '0);
        chk("wr81_strb_once", {112'd0, wr_strb}, 128'd0);
        step(0, 8'h81, 8'h00, 1, 0, '0);
        chk("rd81_data", {120'd0, data_in}, {120'd0, 8'h3C});

        step(0, 8'h82, 8'h05, 0, 1, '0);
        chk("policy_reg2", {120'd0, regs_q[23:16]}, {120'd0, 8'hFA});
        hs = '0; hs[16] = 1'b1;
        step(0, 8'h82, 8'h01, 0, 1, hs);
        chk("set_wins_bit0", {127'd0, regs_q[16]}, 128'd1);

        step(0, 8'h7F, 8'h77, 0, 1, '0);
        step(0, 8'h90, 8'h77, 0, 1, '0);
        chk("miss_no_strb", {112'd0, wr_strb}, 128'd0);
        step(0, 8'h90, 8'h00, 1, 0, '0);
        chk("rd90_data",  {120'd0, data_in}, 128'd0);
        chk("rd90_valid", {127'd0, rd_valid}, 128'd0);

        step(0, 8'h84, 8'h11, 0, 1, '0);
        step(0, 8'h84, 8'h22, 0, 0, '0);
        chk("rdwr84_old", {120'd0, data_in}, {120'd0, 8'h11});
        step(0, 8'h84, 8'h00, 1, 0, '0);
        chk("rd84_new", {120'd0, data_in}, {120'd0, 8'h22});

        step(0, 8'h84, 8'h33, 0, 1, '0);
        step(0, 8'h85, 8'h44, 0, 1, '0);
        step(1, 8'h86, 8'h55, 0, 1, '0);
        chk("midrst_image", regs_q, RST_IMG);
        chk("midrst_strb",  {112'd0, wr_strb}, 128'd0);
        step(0, 8'h84, 8'h66, 0, 1, '0);
        chk("post_rst_wr", {120'd0, regs_q[39:32]}, {120'd0, 8'h66});

        for (int n = 0; n < 400; n++) begin
            hs = '0;
            if ($urandom_range(0, 7) == 0) hs[$urandom_range(0, 127)] = 1'b1;
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 8'($urandom_range(8'h78, 8'h97)),
                 8'($urandom),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 hs);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
